gates_pipe: RTL and testbench

//   Parametrised, pipelined successor to the two-input gates block. Computes one of

---
 rtl/gates_pipe_if.sv | 28 ++
 rtl/gates_pipe.sv | 99 +++++++++
 tb/tb_gates_pipe.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/gates_pipe_if.sv
// Operand and result handshake bundle for gates_pipe.
// The master side drives operands and consumes results. The slave side is the block itself.
interface gates_pipe_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_acc;
    logic             in_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_parity;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_op, in_acc, in_clr, out_ready,
        input  in_ready, out_valid, out_data, out_parity, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_acc, in_clr, out_ready,
        output in_ready, out_valid, out_data, out_parity, out_zero
    );
endinterface

// File: rtl/gates_pipe.sv
// Pipelined bitwise logic unit with an optional accumulator.
// Results are queued in a DEPTH-entry output FIFO that has valid/ready handshakes on both sides.
module gates_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    gates_pipe_if.slave              bus,
    output logic [WIDTH-1:0]         acc_q,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = WIDTH + 2;

    // Each FIFO entry is packed as {result, parity, zero}.
    logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]            level_q, level_d;
    logic [WIDTH-1:0]         acc_d;

    logic [WIDTH-1:0] operand_x;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;
    logic [EW-1:0]    head;

    assign bus.in_ready   = (level_q != LW'(DEPTH));
    assign bus.out_valid  = (level_q != '0);
    assign head           = mem_q[rd_ptr_q];
    assign bus.out_data   = head[EW-1:2];
    assign bus.out_parity = head[1];
    assign bus.out_zero   = head[0];
    assign level          = level_q;

    always_comb begin
        operand_x = bus.in_b;
        if (bus.in_acc) begin
            operand_x = bus.in_clr ? '0 : acc_q;
        end

        result = '0;
        case (bus.in_op)
            3'd0:    result = bus.in_a & operand_x;
            3'd1:    result = bus.in_a | operand_x;
            3'd2:    result = bus.in_a ^ operand_x;
            3'd3:    result = ~(bus.in_a & operand_x);
            3'd4:    result = ~(bus.in_a | operand_x);
            3'd5:    result = ~(bus.in_a ^ operand_x);
            3'd6:    result = ~bus.in_a;
            default: result = bus.in_a;
        endcase
    end

    always_comb begin
        push     = bus.in_valid & bus.in_ready;
        pop      = bus.out_valid & bus.out_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        acc_d    = acc_q;

        if (push) begin
            mem_d[wr_ptr_q] = {result, ^result, (result == '0)};
            wr_ptr_d        = wr_ptr_q + AW'(1);
            if (bus.in_acc) begin
                acc_d = result;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            acc_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: tb/tb_gates_pipe.sv
// Self-checking bench for gates_pipe. It runs directed scenarios and then random traffic.
// All traffic is compared against a queue-based reference model.
module tb_gates_pipe;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] acc_q;
    logic [2:0]       level;

    gates_pipe_if #(.WIDTH(WIDTH)) bus ();

    gates_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .acc_q (acc_q),
        .level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      n_checks = 0;
    int unsigned      n_fail   = 0;
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] model_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] x);
        case (op)
            3'd0:    return a & x;
            3'd1:    return a | x;
            3'd2:    return a ^ x;
            3'd3:    return ~(a & x);
            3'd4:    return ~(a | x);
            3'd5:    return ~(a ^ x);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    // Call this after the inputs have been set at the negedge.
    // It compares the DUT outputs with the model, advances one clock, and updates the model.
    task automatic cycle();
        logic             do_push;
        logic             do_pop;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] r;
        check("in_ready", 32'(bus.in_ready), 32'(model_q.size() != DEPTH));
        check("out_valid", 32'(bus.out_valid), 32'(model_q.size() != 0));
        check("level", 32'(level), model_q.size());
        check("acc_q", 32'(acc_q), 32'(model_acc));
        if (model_q.size() != 0) begin
            check("out_data", 32'(bus.out_data), 32'(model_q[0]));
            check("out_parity", 32'(bus.out_parity), 32'(^model_q[0]));
            check("out_zero", 32'(bus.out_zero), 32'(model_q[0] == 0));
        end
        do_push = bus.in_valid && (model_q.size() < DEPTH);
        do_pop  = bus.out_ready && (model_q.size() > 0);
        x = !bus.in_acc ? bus.in_b : (bus.in_clr ? '0 : model_acc);
        r = ref_op(bus.in_op, bus.in_a, x);
        @(posedge clk);
        if (!rst_n) begin
            model_q.delete();
            model_acc = '0;
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back(r);
                if (bus.in_acc) model_acc = r;
            end
        end
        @(negedge clk);
    endtask

    task automatic beat(input logic v, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic acc, input logic clr, input logic rdy);
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_acc    = acc;
        bus.in_clr    = clr;
        bus.out_ready = rdy;
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = '0;
        bus.in_acc    = 1'b0;
        bus.in_clr    = 1'b0;
        bus.out_ready = 1'b0;
        model_acc     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_level", 32'(level), 0);
        check("rst_acc", 32'(acc_q), 0);
        check("rst_out_data", 32'(bus.out_data), 0);

        // Basic ops with the consumer always ready
        for (int i = 0; i < 4; i++) begin
            beat(1'b1, 3'(i), 8'hC5, 8'h3A, 1'b0, 1'b0, 1'b1);
            check("ops_data", 32'(bus.out_data), (i == 0) ? 32'h00 : 32'hFF);
            check("ops_zero", 32'(bus.out_zero), (i == 0) ? 1 : 0);
        end
        beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        // Full FIFO: a 5th beat is held until space frees up
        for (int i = 0; i < 4; i++) beat(1'b1, 3'd7, 8'(8'h10 + i), 8'h00, 1'b0, 1'b0, 1'b0);
        bus.in_a = 8'h99;
        check("full_in_ready", 32'(bus.in_ready), 0);
        check("full_level", 32'(level), 4);
        beat(1'b1, 3'd7, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0);
        check("full_held", 32'(level), 4);
        for (int i = 0; i < 3; i++) beat(1'b1, 3'd7, 8'h99, 8'h00, 1'b0, 1'b0, 1'b1);
        repeat (3) beat(1'b0, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check("full_drained", 32'(level), 0);

        // Accumulate chain
        beat(1'b1, 3'd2, 8'h0F, 8'hAA, 1'b1, 1'b1, 1'b1);
        check("acc_1", 32'(acc_q), 32'h0F);
        beat(1'b1, 3'd2, 8'hF0, 8'hAA, 1'b1, 1'b0, 1'b1);
        check("acc_2", 32'(acc_q), 32'hFF);
        beat(1'b1, 3'd0, 8'h3C, 8'hAA, 1'b1, 1'b0, 1'b1);
        check("acc_3", 32'(acc_q), 32'h3C);
        beat(1'b1, 3'd1, 8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        check("acc_hold", 32'(acc_q), 32'h3C);
        beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        // Simultaneous push and pop at level 2
        beat(1'b1, 3'd7, 8'h21, 8'h00, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 3'd7, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 3'd7, 8'(8'h30 + i), 8'h00, 1'b0, 1'b0, 1'b1);
            check("simul_level", 32'(level), 2);
        end
        repeat (3) beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of operation
        beat(1'b1, 3'd7, 8'h55, 8'h00, 1'b1, 1'b1, 1'b0);
        beat(1'b1, 3'd6, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b0);
        beat(1'b1, 3'd1, 8'h0F, 8'h80, 1'b0, 1'b0, 1'b0);
        check("mid_level", 32'(level), 3);
        check("mid_acc", 32'(acc_q), 32'h55);
        do_reset();
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_valid", 32'(bus.out_valid), 0);
        check("mid_rst_acc", 32'(acc_q), 0);
        check("mid_rst_data", 32'(bus.out_data), 0);
        repeat (2) beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        // Random traffic with an occasional reset
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            beat(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 2) != 0));
        end
        rst_n = 1'b1;
        repeat (DEPTH + 1) beat(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
